// File: rtl/key_uart_rx_pkg.sv
// Shared constants, FSM state encoding and small helpers for the keyboard UART receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: silence/release key codes, 16x oversampling factor, receiver state enum,
// width helper that never returns zero, and the "does this byte silence the note" test.
package key_uart_rx_pkg;

  localparam logic [7:0] KEY_NONE         = 8'h00;
  localparam logic [7:0] KEY_RELEASE      = 8'h20;
  localparam int         DEFAULT_CLK_FREQ = 100_000_000;
  localparam int         OVERSAMPLE       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // $clog2 collapses to 0 for n<=1; counters still need at least one bit.
  function automatic int safe_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // NUL and space both mean "release the current note".
  function automatic logic is_silence(input logic [7:0] b);
    return (b == KEY_NONE) || (b == KEY_RELEASE);
  endfunction

endpackage

// File: rtl/key_uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, 16x tick generator, start/data/stop/break FSM.
// Latency: strobe/frame-error pulse registered on the edge after the stop-bit sample.
// Backpressure: none; every byte is presented once on rx_strobe_o and must be taken then.
//
// Ports:
//   clk            master clock
//   rst            synchronous active-high reset
//   rx_i           asynchronous serial line, idle high
//   rx_byte_o      last assembled byte (valid while rx_strobe_o is high)
//   rx_strobe_o    1-cycle pulse, byte received with a good stop bit
//   rx_frame_err_o 1-cycle pulse, stop bit sampled low
module key_uart_rx_core
  import key_uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_strobe_o,
  output logic       rx_frame_err_o
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = safe_width(DIV);
  localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);

  // ---------------- synchronizer + edge history ----------------
  logic sync1_q, sync2_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // ---------------- free-running 16x tick ----------------
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // ---------------- receive FSM ----------------
  rx_state_e  state_q;
  logic [3:0] phase_q;     // ticks within the current bit (or high-run length in BREAK)
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       strobe_q;
  logic       ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      strobe_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_prev_q && !sync2_q) begin
            state_q <= ST_START;
            phase_q <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (phase_q == 4'd7) begin
              // Mid start bit: re-zero phase so later samples land mid-bit.
              phase_q <= '0;
              if (!sync2_q) begin
                state_q   <= ST_DATA;
                bit_idx_q <= '0;
              end else begin
                state_q <= ST_IDLE;
              end
            end else begin
              phase_q <= phase_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              shift_q   <= {sync2_q, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_q <= ST_STOP;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
              if (sync2_q) begin
                strobe_q <= 1'b1;
                state_q  <= ST_IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= ST_BREAK;
                phase_q <= '0;
              end
            end
          end
        end
        ST_BREAK: begin
          // Leave only after 16 consecutive high ticks; any low tick restarts the run.
          if (tick) begin
            if (!sync2_q) begin
              phase_q <= '0;
            end else if (phase_q == 4'd15) begin
              state_q <= ST_IDLE;
              phase_q <= '0;
            end else begin
              phase_q <= phase_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_byte_o      = shift_q;
  assign rx_strobe_o    = strobe_q;
  assign rx_frame_err_o = ferr_q;

endmodule

// File: rtl/key_uart_rx.sv
// Keyboard serial front end: UART receive plus key-hold register with expiry timer.
// Latency: outKey/outValid update 1 clk after the receiver strobe (2 clk after stop sample edge).
// Backpressure: none; last received key always wins, nothing is queued.
//
// Ports:
//   clk          master clock
//   rst          synchronous active-high reset
//   inRx         asynchronous UART line, idle high
//   outKey       held key code, 8'h00 = silence
//   outValid     1-cycle pulse per accepted byte
//   outActive    high while outKey is non-zero
//   outFrameErr  1-cycle pulse when a stop bit samples low
module key_uart_rx
  import key_uart_rx_pkg::*;
#(
  parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
  parameter int BAUD        = 115200,
  parameter int HOLD_CYCLES = 60_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inRx,
  output logic [7:0] outKey,
  output logic       outValid,
  output logic       outActive,
  output logic       outFrameErr
);

  localparam int HW = safe_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       rx_frame_err;

  key_uart_rx_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_core (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (inRx),
    .rx_byte_o     (rx_byte),
    .rx_strobe_o   (rx_strobe),
    .rx_frame_err_o(rx_frame_err)
  );

  logic [7:0]    key_q, key_d;
  logic [HW-1:0] timer_q, timer_d;
  logic          active_q;
  logic          valid_q;
  logic          ferr_q;

  // A new byte takes precedence over expiry, so a key arriving on the
  // expiry cycle reloads instead of dropping to silence for one clock.
  always_comb begin
    key_d   = key_q;
    timer_d = timer_q;
    if (rx_strobe) begin
      if (is_silence(rx_byte)) begin
        key_d   = KEY_NONE;
        timer_d = '0;
      end else begin
        key_d   = rx_byte;
        timer_d = HOLD_LOAD;
      end
    end else if (key_q != KEY_NONE) begin
      if (timer_q != '0) begin
        timer_d = timer_q - HW'(1);
      end else begin
        key_d = KEY_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= KEY_NONE;
      timer_q  <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      key_q    <= key_d;
      timer_q  <= timer_d;
      active_q <= (key_d != KEY_NONE);
      valid_q  <= rx_strobe;
      ferr_q   <= rx_frame_err;
    end
  end

  assign outKey      = key_q;
  assign outValid    = valid_q;
  assign outActive   = active_q;
  assign outFrameErr = ferr_q;

endmodule
